// File: rtl/blast_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : blast_scan_ctrl
// Brief   : Slides an 11-base window over a streamed DB, sequences the seed
//           comparator and queues threshold hits in a valid/ready FIFO.
// Revision: 1.0
// ============================================================================
module blast_scan_ctrl #(
    parameter int POS_W     = 16,
    parameter int HIT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [21:0]      query,
    input  logic [5:0]       cfg_thresh,
    input  logic             db_valid,
    input  logic [1:0]       db_base,
    input  logic             db_last,
    output logic             db_ready,
    output logic [21:0]      cmp_query,
    output logic [21:0]      cmp_db,
    input  logic [5:0]       cmp_score,
    output logic             hit_valid,
    output logic [POS_W-1:0] hit_pos,
    output logic [5:0]       hit_score,
    input  logic             hit_ready,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] hit_count
);
    localparam int         AW        = $clog2(HIT_DEPTH);
    localparam int         OW        = AW + 2;
    localparam logic [3:0] LAST_FILL = 4'd10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        SCAN  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state, state_nx;
    logic [21:0]        query_q, window;
    logic [5:0]         thresh_q;
    logic [3:0]         fill_cnt;
    logic [POS_W-1:0]   issue_pos, pos_d;
    logic               issue_v, score_v;
    logic [POS_W+5:0]   fifo_mem [HIT_DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr, fifo_count;
    logic [OW-1:0]      occupancy;
    logic               accept, fill_done, issue_now, push, pop;

    // Every compare in flight holds a FIFO slot, so the FIFO can never overflow.
    assign fifo_count = wr_ptr - rd_ptr;
    assign occupancy  = OW'(fifo_count) + OW'(issue_v) + OW'(score_v);
    assign db_ready   = (state == FILL) || ((state == SCAN) && (occupancy < OW'(HIT_DEPTH)));
    assign accept     = db_valid && db_ready;
    assign fill_done  = (state == FILL) && accept && (fill_cnt == LAST_FILL);
    assign issue_now  = fill_done || ((state == SCAN) && accept);
    assign push       = score_v && (cmp_score >= thresh_q);
    assign hit_valid  = (fifo_count != '0);
    assign pop        = hit_valid && hit_ready;

    assign cmp_query  = query_q;
    assign cmp_db     = window;
    assign hit_pos    = fifo_mem[rd_ptr[AW-1:0]][POS_W+5:6];
    assign hit_score  = fifo_mem[rd_ptr[AW-1:0]][5:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    if (db_last) begin
                        state_nx = DRAIN;
                    end else if (fill_cnt == LAST_FILL) begin
                        state_nx = SCAN;
                    end
                end
            end
            SCAN: begin
                if (accept && db_last) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!issue_v && !score_v && !hit_valid) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            query_q   <= '0;
            thresh_q  <= '0;
            window    <= '0;
            fill_cnt  <= '0;
            issue_pos <= '0;
            pos_d     <= '0;
            issue_v   <= 1'b0;
            score_v   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hit_count <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                query_q   <= query;
                thresh_q  <= cfg_thresh;
                fill_cnt  <= '0;
                issue_pos <= '0;
                hit_count <= '0;
            end
            if (accept) begin
                window <= {window[19:0], db_base};
                if (state == FILL) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
            // issue_pos names the window that issue_v is carrying this cycle.
            if (fill_done) begin
                issue_pos <= '0;
            end else if (issue_now) begin
                issue_pos <= issue_pos + 1'b1;
            end
            issue_v <= issue_now;
            score_v <= issue_v;
            if (issue_v) begin
                pos_d <= issue_pos;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (hit_count != {POS_W{1'b1}}) begin
                    hit_count <= hit_count + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {pos_d, cmp_score};
        end
    end

endmodule
`default_nettype wire
